// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC register driving a combinational ROM, feeding a circular
// queue of {word, pc} entries delivered over a valid/ready handshake.
module fetch_queue #(
    parameter int unsigned A = 4,
    parameter int unsigned W = 9,
    parameter int unsigned D = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [A-1:0]           start_addr,
    input  logic                   halt,
    input  logic                   branch_valid,
    input  logic                   branch_rel,
    input  logic [A-1:0]           branch_pc,
    input  logic [A-1:0]           branch_operand,
    output logic [A-1:0]           rom_addr,
    input  logic [W-1:0]           rom_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [W-1:0]           inst_out,
    output logic [A-1:0]           inst_pc,
    output logic                   halted,
    output logic [$clog2(D+1)-1:0] count
);
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 1);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e        state_q;
    logic [A-1:0]  pc_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  mem_inst [D];
    logic [A-1:0]  mem_pc   [D];

    logic         pop;
    logic         fetch;
    logic         redirect;
    logic [A-1:0] target;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
    assign fetch      = (state_q == StRun) & ~start & ~branch_valid & ~halt &
                        ((count_q < CW'(D)) | pop);
    assign redirect   = branch_valid & (state_q != StIdle);
    assign target     = branch_rel ? (branch_pc + branch_operand) : branch_operand;

    assign rom_addr = pc_q;
    assign count    = count_q;
    assign halted   = (state_q == StHalted);
    assign inst_out = inst_valid ? mem_inst[rd_ptr_q] : '0;
    assign inst_pc  = inst_valid ? mem_pc[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (start) begin
            state_q  <= StRun;
            pc_q     <= start_addr;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            // Any pop this cycle has already been taken downstream; the rest is discarded.
            pc_q     <= target;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            if (state_q == StRun && halt) state_q <= StHalted;
        end else begin
            if (state_q == StRun && halt) state_q <= StHalted;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (fetch) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                pc_q     <= pc_q + 1'b1;
            end
            if (fetch && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !fetch) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) begin
            mem_inst[wr_ptr_q] <= rom_data;
            mem_pc[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: a queue-based model predicts deliveries,
// a negedge monitor compares every handshake and the occupancy/halt/pc outputs.
module tb_fetch_queue;
    localparam int A = 4;
    localparam int W = 9;
    localparam int D = 4;
    localparam int NPC = 1 << A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start;
    logic [A-1:0]  start_addr;
    logic          halt;
    logic          branch_valid;
    logic          branch_rel;
    logic [A-1:0]  branch_pc;
    logic [A-1:0]  branch_operand;
    logic [A-1:0]  rom_addr;
    logic [W-1:0]  rom_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [W-1:0]  inst_out;
    logic [A-1:0]  inst_pc;
    logic          halted;
    logic [$clog2(D+1)-1:0] count;

    logic [W-1:0] rom [NPC];
    assign rom_data = rom[rom_addr];

    fetch_queue #(.A(A), .W(W), .D(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .halt           (halt),
        .branch_valid   (branch_valid),
        .branch_rel     (branch_rel),
        .branch_pc      (branch_pc),
        .branch_operand (branch_operand),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .count          (count)
    );

    typedef struct {
        logic [W-1:0] w;
        logic [A-1:0] pc;
    } ent_t;

    ent_t mq[$];     // model of the queue contents
    ent_t exp_q[$];  // scoreboard: entries expected to be handed downstream
    ent_t mon_e;
    int   mpc;
    int   mst;       // 0 idle, 1 run, 2 halted
    int   e_count, e_halted, e_pc;
    bit   chk_en;
    int   total, bad;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic snap();
        e_count  = mq.size();
        e_halted = (mst == 2) ? 1 : 0;
        e_pc     = mpc;
    endtask

    task automatic idle_inputs();
        start = 0; start_addr = '0; halt = 0; branch_valid = 0; branch_rel = 0;
        branch_pc = '0; branch_operand = '0; inst_ready = 0;
    endtask

    // One clock cycle of stimulus, followed by the reference model's step for that edge.
    task automatic cyc(input bit s, input int sa, input bit h, input bit bv, input bit br,
                       input int bpc, input int bop, input bit rdy);
        ent_t t;
        @(posedge clk);
        #1;
        start = s; start_addr = A'(sa); halt = h; branch_valid = bv; branch_rel = br;
        branch_pc = A'(bpc); branch_operand = A'(bop); inst_ready = rdy;
        snap();
        if (mq.size() != 0 && rdy) begin
            t = mq.pop_front();
            exp_q.push_back(t);
        end
        if (s) begin
            mq.delete();
            mpc = sa;
            mst = 1;
        end else if (bv && mst != 0) begin
            mq.delete();
            mpc = br ? (bpc + bop) % NPC : bop;
            if (mst == 1 && h) mst = 2;
        end else begin
            if (mst == 1 && !h && mq.size() < D) begin
                t.w  = rom[mpc];
                t.pc = A'(mpc);
                mq.push_back(t);
                mpc = (mpc + 1) % NPC;
            end
            if (mst == 1 && h) mst = 2;
        end
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("inst_valid", int'(inst_valid), (e_count != 0) ? 1 : 0);
            check("count", int'(count), e_count);
            check("halted", int'(halted), e_halted);
            check("rom_addr", int'(rom_addr), e_pc);
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got pc %0d expected no delivery", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("inst_out", int'(inst_out), int'(mon_e.w));
                    check("inst_pc", int'(inst_pc), int'(mon_e.pc));
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; chk_en = 0;
        for (int i = 0; i < NPC; i++) rom[i] = W'(i) | W'($urandom_range(0, 31) << 4);
        idle_inputs();
        mq.delete(); exp_q.delete(); mpc = 0; mst = 0;
        reset_n = 0;
        #2;
        check("rst_valid", int'(inst_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_inst_out", int'(inst_out), 0);
        check("rst_inst_pc", int'(inst_pc), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        @(negedge clk);
        reset_n = 1;
        snap();
        chk_en = 1;

        // Idle: no fetch, branch ignored.
        run(2, 1);
        cyc(0, 0, 0, 1, 0, 0, 9, 1);
        run(2, 1);

        // Streaming from 0 with wrap 15 -> 0.
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        run(20, 1);

        // Back-pressure: fill to D, hold, then drain with no gap.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(6, 0);
        run(8, 1);

        // Absolute branch to 9 with 3 entries queued.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(3, 0);
        cyc(0, 0, 0, 1, 0, 0, 9, 0);
        run(5, 1);

        // Relative branches: 14 + 3 -> 1, 2 + (-2) -> 0; also with a pop in the branch cycle.
        cyc(0, 0, 0, 1, 1, 14, 3, 1);
        run(4, 1);
        cyc(0, 0, 0, 1, 1, 2, 14, 1);
        run(4, 1);

        // Halt with 2 queued, drain, stay halted, restart at 5.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(2, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 1);
        run(2, 1);
        cyc(0, 0, 0, 1, 0, 0, 3, 1);
        run(2, 1);
        cyc(1, 5, 0, 0, 0, 0, 0, 1);
        run(4, 1);

        // Halt and branch together, then start with halt/branch also asserted.
        cyc(0, 0, 1, 1, 0, 0, 12, 1);
        run(2, 1);
        cyc(1, 3, 1, 1, 0, 0, 8, 1);
        run(6, 0);
        run(3, 1);

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            cyc($urandom_range(0, 99) < 4, $urandom_range(0, NPC - 1),
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
                $urandom_range(0, 1) == 1, $urandom_range(0, NPC - 1),
                $urandom_range(0, NPC - 1), $urandom_range(0, 99) < 70);
        end

        // Asynchronous reset between edges mid-stream.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(3, 0);
        #2;
        chk_en = 0;
        reset_n = 0;
        idle_inputs();
        #1;
        check("async_valid", int'(inst_valid), 0);
        check("async_count", int'(count), 0);
        check("async_halted", int'(halted), 0);
        check("async_rom_addr", int'(rom_addr), 0);
        mq.delete(); exp_q.delete(); mpc = 0; mst = 0;
        #20;
        reset_n = 1;
        snap();
        chk_en = 1;
        run(3, 1);
        cyc(1, 7, 0, 0, 0, 0, 0, 1);
        run(10, 1);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
